// File: rtl/upe_resign_sched_pkg.sv
// Shared types and constants for the resign scheduler: slot FSM encoding,
// data width, saturation constants and the 32-bit negate helper.
package upe_resign_sched_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;
  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Two's complement negate; -0 = 0 and -SAT_MIN wraps to SAT_MIN.
  function automatic logic [DATA_W-1:0] negate32(input logic [DATA_W-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/upe_resign_sched_if.sv
// Request/response bundle between the coefficient-sign stages (master) and
// the shared resign scheduler (slave).
interface upe_resign_sched_if #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
);
  // Requesters hold req high with stable data until they see gnt in the
  // accept cycle; the output slot transfers on any edge with
  // out_valid && out_ready, and out_data/out_tag are stable while stalled.
  logic [NREQ-1:0]    req;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_sign;
  logic [NREQ-1:0]    gnt;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic [TAGW-1:0]    out_tag;

  modport master (
    output req, req_data, req_sign, out_ready,
    input  gnt, out_valid, out_data, out_tag
  );

  modport slave (
    input  req, req_data, req_sign, out_ready,
    output gnt, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/upe_rr_arbiter.sv
// Round-robin arbiter: search starts at the rotating pointer and wraps; the
// pointer moves past the winner only when the caller advances.
module upe_rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx
);

  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            found;

  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/upe_resign_sched.sv
// Shared conditional-negate unit for NREQ requesters with one registered
// output slot. Build option UPE_RESIGN_SATURATE_EN saturates -0x80000000 and adds ovf.
module upe_resign_sched
  import upe_resign_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2,
  parameter int CNTW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  upe_resign_sched_if.slave   bus,
  output logic [CNTW-1:0]     ops_done,
  output logic                busy,
  output state_e              dbg_state_o
`ifdef UPE_RESIGN_SATURATE_EN
  ,
  output logic                ovf
`endif
);

  localparam int IDXW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [CNTW-1:0]   ops_q, ops_d;

  logic              accept, drain;
  logic [NREQ-1:0]   cand_gnt;
  logic [IDXW-1:0]   cand_idx;
  logic [DATA_W-1:0] operand, result;
  logic              sign_sel;

  // Reset gates accept so no grant leaks out during the reset cycle.
  assign accept = rst_n && (|bus.req) && (state_q == ST_EMPTY || bus.out_ready);
  assign drain  = (state_q == ST_FULL) && bus.out_ready;

  upe_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .advance (accept),
    .gnt     (cand_gnt),
    .gnt_idx (cand_idx)
  );

  always_comb begin
    operand  = '0;
    sign_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand_idx == IDXW'(i)) begin
        operand  = bus.req_data[DATA_W*i +: DATA_W];
        sign_sel = bus.req_sign[i];
      end
    end
  end

`ifdef UPE_RESIGN_SATURATE_EN
  logic sat_hit;
  logic ovf_q, ovf_d;
  assign sat_hit = sign_sel && (operand == SAT_MIN);
  assign result  = sat_hit ? SAT_MAX : (sign_sel ? negate32(operand) : operand);
`else
  assign result  = sign_sel ? negate32(operand) : operand;
`endif

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    tag_d   = tag_q;
    ops_d   = ops_q;
    if (accept) begin
      state_d = ST_FULL;
      data_d  = result;
      tag_d   = TAGW'(cand_idx);
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
    if (drain) ops_d = ops_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      tag_q   <= '0;
      ops_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      ops_q   <= ops_d;
    end
  end

`ifdef UPE_RESIGN_SATURATE_EN
  always_comb begin
    ovf_d = ovf_q;
    if (accept) ovf_d = sat_hit;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

  assign bus.gnt       = accept ? cand_gnt : '0;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_tag   = tag_q;
  assign ops_done      = ops_q;
  assign busy          = (state_q == ST_FULL) || (|bus.req);
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_upe_resign_sched.sv
// Directed bench for upe_resign_sched: reset, sign handling, round-robin
// order, backpressure, min-int negate, mid-run reset and counter wrap.
module tb_upe_resign_sched;
  import upe_resign_sched_pkg::*;

  logic clk;
  logic rst_n;
  logic [15:0] ops_done;
  logic busy;
  state_e dbg_state;
`ifdef UPE_RESIGN_SATURATE_EN
  logic ovf;
`endif

  int errors = 0;
  int checks = 0;

  upe_resign_sched_if #(.NREQ(4), .TAGW(2)) bus ();

  upe_resign_sched #(.NREQ(4), .TAGW(2), .CNTW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .ops_done    (ops_done),
    .busy        (busy),
    .dbg_state_o (dbg_state)
`ifdef UPE_RESIGN_SATURATE_EN
    ,
    .ovf         (ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] d, input logic s);
    bus.req_data[32*i +: 32] = d;
    bus.req_sign[i]          = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_sign  = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_tag !== 2'd0 ||
        ops_done !== 16'd0 || dbg_state !== ST_EMPTY) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%h tag=%0d ops=%0d st=%0d exp 0/0/0/0/0",
               bus.out_valid, bus.out_data, bus.out_tag, ops_done, dbg_state);
    end
    @(negedge clk);
    bus.req = '0;
    rst_n   = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    @(negedge clk);
    set_op(0, 32'h0000_0005, 1'b1);
    bus.req       = 4'b0001;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL basic_gnt got=%b exp=0001", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hFFFF_FFFB || bus.out_tag !== 2'd0) begin
      errors++;
      $display("FAIL basic_out valid=%b data=%h tag=%0d exp 1/fffffffb/0",
               bus.out_valid, bus.out_data, bus.out_tag);
    end
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'd1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_ops ops=%0d valid=%b exp 1/0", ops_done, bus.out_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_gnt[5];
    logic [1:0]  exp_tag[5];
    logic [31:0] exp_data[5];
    exp_gnt  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_tag  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_data = '{32'hFFFF_FF00, 32'h0000_0200, 32'hFFFF_FD00, 32'h0000_0400, 32'hFFFF_FF00};
    do_reset();
    @(negedge clk);
    set_op(0, 32'h100, 1'b1);
    set_op(1, 32'h200, 1'b0);
    set_op(2, 32'h300, 1'b1);
    set_op(3, 32'h400, 1'b0);
    bus.req       = 4'b1111;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (bus.gnt !== exp_gnt[n]) begin
        errors++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", n, bus.gnt, exp_gnt[n]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== exp_tag[n] || bus.out_data !== exp_data[n]) begin
        errors++;
        $display("FAIL rr_out[%0d] valid=%b tag=%0d data=%h exp 1/%0d/%h",
                 n, bus.out_valid, bus.out_tag, bus.out_data, exp_tag[n], exp_data[n]);
      end
      @(negedge clk);
    end
    bus.req = '0;
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'd5) begin
      errors++; $display("FAIL rr_ops got=%0d exp=5", ops_done);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    set_op(2, 32'h1234_5678, 1'b0);
    bus.req       = 4'b0100;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    set_op(0, 32'h0000_000A, 1'b0);
    set_op(1, 32'h0000_0001, 1'b1);
    bus.req = 4'b0011;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (bus.gnt !== 4'b0000) begin
        errors++; $display("FAIL bp_gnt[%0d] got=%b exp=0000", n, bus.gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234_5678 || bus.out_tag !== 2'd2) begin
        errors++;
        $display("FAIL bp_hold[%0d] valid=%b data=%h tag=%0d exp 1/12345678/2",
                 n, bus.out_valid, bus.out_data, bus.out_tag);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL bp_refill_gnt got=%b exp=0001", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h0000_000A || bus.out_tag !== 2'd0 ||
        ops_done !== 16'd1) begin
      errors++;
      $display("FAIL bp_refill valid=%b data=%h tag=%0d ops=%0d exp 1/0000000a/0/1",
               bus.out_valid, bus.out_data, bus.out_tag, ops_done);
    end
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_min_int();
    logic [31:0] exp_min;
`ifdef UPE_RESIGN_SATURATE_EN
    exp_min = 32'h7FFF_FFFF;
`else
    exp_min = 32'h8000_0000;
`endif
    do_reset();
    @(negedge clk);
    set_op(1, 32'h8000_0000, 1'b1);
    set_op(0, 32'h0000_0000, 1'b1);
    bus.req       = 4'b0010;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++; $display("FAIL min_gnt got=%b exp=0010", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_data !== exp_min || bus.out_tag !== 2'd1) begin
      errors++; $display("FAIL min_data data=%h tag=%0d exp %h/1", bus.out_data, bus.out_tag, exp_min);
    end
`ifdef UPE_RESIGN_SATURATE_EN
    checks++;
    if (ovf !== 1'b1) begin
      errors++; $display("FAIL min_ovf got=%b exp=1", ovf);
    end
`endif
    @(negedge clk);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    checks++;
    if (bus.out_data !== 32'h0 || bus.out_tag !== 2'd0) begin
      errors++; $display("FAIL neg_zero data=%h tag=%0d exp 00000000/0", bus.out_data, bus.out_tag);
    end
`ifdef UPE_RESIGN_SATURATE_EN
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL zero_ovf got=%b exp=0", ovf);
    end
`endif
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    set_op(0, 32'h11, 1'b0);
    set_op(1, 32'h22, 1'b0);
    set_op(2, 32'h33, 1'b0);
    set_op(3, 32'h44, 1'b0);
    bus.req       = 4'b0001;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.req = 4'b0010;
    @(posedge clk); #1;
    @(negedge clk);
    bus.req       = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'd1 || bus.out_valid !== 1'b1 || bus.out_tag !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre ops=%0d valid=%b tag=%0d exp 1/1/1", ops_done, bus.out_valid, bus.out_tag);
    end
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b1110;
    #1;
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL mid_rst_gnt got=%b exp=0000", bus.gnt);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || ops_done !== 16'd0 || dbg_state !== ST_EMPTY) begin
      errors++;
      $display("FAIL mid_rst_state valid=%b ops=%0d st=%0d exp 0/0/0", bus.out_valid, ops_done, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.gnt !== 4'b0010) begin
      errors++; $display("FAIL mid_first_gnt got=%b exp=0010", bus.gnt);
    end
    bus.req = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    set_op(0, 32'h7, 1'b0);
    bus.req       = 4'b0001;
    bus.out_ready = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_pre got=%h exp=ffff", ops_done);
    end
    @(negedge clk);
    bus.req = 4'b0001;
    @(posedge clk); #1;
    @(negedge clk);
    bus.req = '0;
    @(posedge clk); #1;
    checks++;
    if (ops_done !== 16'h0000) begin
      errors++; $display("FAIL wrap_zero got=%h exp=0000", ops_done);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.req_sign  = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_min_int();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/upe_resign_sched.md
Name: upe_resign_sched

Overview:
- Shares one 32-bit conditional-negate datapath (Out = sign ? -In : In) between NREQ requesters.
- Round-robin arbitration picks one requester per cycle; its operand passes through the datapath into a single registered output slot with valid/ready backpressure.
- Sits between the UPE coefficient-sign stages and the downstream accumulator, so those stages do not each carry their own negate unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TAGW, 2, width of the requester index on the output; must satisfy 2^TAGW >= NREQ.
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req  in  NREQ  per-requester request; held high with stable data until granted.
- req_data  in  32*NREQ  operands; requester i occupies bits [32i+31:32i].
- req_sign  in  NREQ  per-requester sign; 1 = negate, 0 = pass through.
- gnt  out  NREQ  one-hot acceptance pulse, asserted combinationally in the accept cycle.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  downstream accepts the result this cycle.
- out_data  out  32  result, two's complement.
- out_tag  out  TAGW  index of the requester that produced out_data.
- ops_done  out  CNTW  count of results consumed downstream.
- busy  out  1  high when out_valid is high or any req bit is high.

Behaviour:
- Reset (rst_n low at a clock edge): out_valid=0, out_data=0, out_tag=0, ops_done=0, rr pointer=0, FSM=EMPTY. gnt is 0 while rst_n is low.
- Reset mid-operation: discards any held result; no gnt pulse is produced in the reset cycle.
- FSM states:
  - EMPTY: output slot free.
  - FULL: slot holds a result.
- Accept condition: any req bit high AND (state==EMPTY OR out_ready). Draining and refilling in the same cycle is allowed, giving back-to-back throughput of 1 result per cycle.
- Arbitration:
  - Search starts at the rr pointer and wraps modulo NREQ; the first set req bit wins.
  - On accept, gnt[winner]=1 and the pointer becomes (winner+1) mod NREQ.
  - With no accept, the pointer holds.
- Latency: 1 cycle. The operand accepted at edge k appears on out_data/out_tag with out_valid=1 after edge k.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→FULL on accept while out_ready (new result loaded).
  - FULL→FULL while !out_ready; out_data and out_tag stay stable.
  - FULL→EMPTY on out_ready with no accept.
- ops_done increments by 1 on each out_valid&&out_ready and wraps from 2^CNTW-1 to 0.
- Arithmetic:
  - Negate is 32-bit two's complement; -0 = 0.
  - With the optional feature off, -0x80000000 = 0x80000000.
- A requester that drops req without a grant is simply skipped; no state is recorded for it.

Optional Feature:
- Macro: UPE_RESIGN_SATURATE_EN.
- Defined:
  - Negating 0x80000000 produces 0x7FFFFFFF.
  - An extra output port ovf (1 bit) is registered with the result: high when saturation occurred, reset 0, stable under backpressure.
- Undefined:
  - Wrap-around result as above.
  - ovf port absent.

Decomposition:
- Shared header "upe-resign-defs.v" (include-guarded) holds:
  - FSM state encodings (EMPTY=1'b0, FULL=1'b1).
  - The 32-bit data width define.
  - The saturation constants 0x80000000 and 0x7FFFFFFF.
- Sub-module upe_rr_arbiter is natural:
  - Parameter NREQ.
  - Inputs: clk, rst_n, req, advance.
  - Outputs: gnt (one-hot), gnt_idx.
  - It owns the rr pointer.
- Negation reuses the existing 32-bit negate unit.

Test Plan:
- Reset, then req=0001, data0=0x00000005, sign0=1, out_ready=1 → gnt=0001; next cycle out_valid=1, out_data=0xFFFFFFFB, out_tag=0; ops_done=1 one edge later.
- All four requesters held with out_ready=1 → gnt order 0001, 0010, 0100, 1000, 0001; one result per cycle; tags 0,1,2,3,0.
- out_ready=0 for 3 cycles with the slot FULL (data 0x12345678, tag 2) → out_data/out_tag unchanged, gnt=0; when ready rises, drain and refill happen in one cycle.
- req1 with 0x80000000, sign=1 → out_data=0x80000000 without UPE_RESIGN_SATURATE_EN; 0x7FFFFFFF with ovf=1 with it.
- rst_n low for one cycle while FULL and requests pending → out_valid=0, ops_done=0, pointer=0; the first grant after release goes to the lowest set req.
- Preload ops_done near wrap via 2^CNTW-1 transfers, then one more transfer → ops_done=0.
